// File: rtl/sig_mon_pkg.sv
// Shared defaults and FSM encoding for the signature window monitor.
// Optional toggle counting is enabled with SIG_MON_TOGGLE_EN (see top).
package sig_mon_pkg;

  localparam int          SIG_W_DEF = 16;
  localparam int          CNT_W_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'hB400;
  localparam logic [15:0] SEED_DEF  = 16'h0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sig_misr_step.sv
// One Galois MISR step: shift right, fold POLY in when the low bit xor the sample is set.
// Purely combinational, zero latency, no flow control.
module sig_misr_step
  import sig_mon_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF)
) (
  input  logic [SIG_W-1:0] cur,
  input  logic             obs_bit,
  output logic [SIG_W-1:0] next
);

  logic fb;

  assign fb   = cur[0] ^ obs_bit;
  assign next = (cur >> 1) ^ (fb ? POLY : '0);

endmodule

// File: rtl/sig_mon_pkg.sig_window_monitor_shared.sv


// File: rtl/sig_window_monitor.sv
// Compacts a window of valid obs_bit samples into a MISR signature and compares it to golden; done one cycle after last sample.
// No backpressure: samples are taken whenever obs_valid is high in RUN. SIG_MON_TOGGLE_EN adds toggle_count.
module sig_window_monitor
  import sig_mon_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter int               CNT_W = CNT_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic [CNT_W-1:0] window_len,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic             obs_valid,
  input  logic             obs_bit,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] ones_count
`ifdef SIG_MON_TOGGLE_EN
  ,
  output logic [CNT_W-1:0] toggle_count
`endif
);

  state_t           state, state_nxt;
  logic [SIG_W-1:0] sig_q, sig_step, golden_q;
  logic [CNT_W-1:0] len_q, sample_cnt, ones_q;
  logic             accept, last_sample, launch;

  assign launch      = start && (state != RUN);
  assign accept      = (state == RUN) && obs_valid;
  assign last_sample = accept && ((sample_cnt + CNT_W'(1)) == len_q);

  sig_misr_step #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_step (
    .cur     (sig_q),
    .obs_bit (obs_bit),
    .next    (sig_step)
  );

  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (window_len == '0) ? DONE : RUN;
      RUN:        if (last_sample) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // A reset mid-window simply reloads SEED, so the partial signature never surfaces.
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      sig_q      <= SEED;
      golden_q   <= '0;
      len_q      <= '0;
      sample_cnt <= '0;
      ones_q     <= '0;
    end else if (launch) begin
      sig_q      <= SEED;
      golden_q   <= golden_sig;
      len_q      <= window_len;
      sample_cnt <= '0;
      ones_q     <= '0;
    end else if (accept) begin
      sig_q      <= sig_step;
      sample_cnt <= sample_cnt + CNT_W'(1);
      ones_q     <= ones_q + CNT_W'(obs_bit);
    end
  end

`ifdef SIG_MON_TOGGLE_EN
  logic [CNT_W-1:0] toggle_q;
  logic             prev_bit;

  // sample_cnt==0 marks the first sample of the window, which has no predecessor.
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst || launch) begin
      toggle_q <= '0;
      prev_bit <= 1'b0;
    end else if (accept) begin
      prev_bit <= obs_bit;
      if (sample_cnt != '0 && obs_bit != prev_bit) toggle_q <= toggle_q + CNT_W'(1);
    end
  end

  assign toggle_count = toggle_q;
`endif

  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign mismatch   = done && (sig_q != golden_q);
  assign signature  = sig_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_sig_window_monitor.sv
// Scoreboard bench for sig_window_monitor; build with SIG_MON_TOGGLE_EN to also cover toggle_count.
module tb_sig_window_monitor;
  import sig_mon_pkg::*;

  typedef struct {
    logic [15:0] sig;
    logic [15:0] ones;
    logic [15:0] tog;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] window_len = '0;
  logic [15:0] golden_sig = '0;
  logic        obs_valid = 1'b0;
  logic        obs_bit = 1'b0;
  logic        busy, done, mismatch;
  logic [15:0] signature, ones_count;
`ifdef SIG_MON_TOGGLE_EN
  logic [15:0] toggle_count;
`endif

  sig_window_monitor dut (
    .I1470_clk    (clk),
    .I1477_rst    (rst),
    .start        (start),
    .window_len   (window_len),
    .golden_sig   (golden_sig),
    .obs_valid    (obs_valid),
    .obs_bit      (obs_bit),
    .busy         (busy),
    .done         (done),
    .mismatch     (mismatch),
    .signature    (signature),
    .ones_count   (ones_count)
`ifdef SIG_MON_TOGGLE_EN
    ,
    .toggle_count (toggle_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference Galois MISR, written straight from the update rule.
  function automatic logic [15:0] model_sig(input int len, input logic [31:0] bits);
    logic [15:0] s;
    logic        fb;
    s = 16'h0001;
    for (int i = 0; i < len; i++) begin
      fb = s[0] ^ bits[i];
      s  = s >> 1;
      if (fb) s = s ^ 16'hB400;
    end
    return s;
  endfunction

  task automatic run_window(input string tag, input int len, input logic [15:0] golden,
                            input logic [31:0] bits, input logic [31:0] gaps);
    exp_t e;
    int   waited;
    e.sig  = model_sig(len, bits);
    e.ones = '0;
    e.tog  = '0;
    for (int i = 0; i < len; i++) begin
      e.ones += 16'(bits[i]);
      if (i > 0 && bits[i] != bits[i-1]) e.tog += 16'd1;
    end
    e.mis = (e.sig != golden);
    exp_q.push_back(e);

    window_len = 16'(len);
    golden_sig = golden;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gaps[i]) begin
        obs_valid = 1'b0;
        obs_bit   = ~bits[i];
        tick();
      end
      check({tag, "_early_done"}, 32'(done), 32'd0);
      obs_valid = 1'b1;
      obs_bit   = bits[i];
      tick();
      obs_valid = 1'b0;
    end

    waited = 0;
    while (!done && waited < 10) begin
      tick();
      waited++;
    end
    check({tag, "_done_latency"}, 32'(waited), 32'd0);

    e = exp_q.pop_front();
    check({tag, "_sig"},      32'(signature),  32'(e.sig));
    check({tag, "_ones"},     32'(ones_count), 32'(e.ones));
    check({tag, "_mismatch"}, 32'(mismatch),   32'(e.mis));
    check({tag, "_busy"},     32'(busy),       32'd0);
`ifdef SIG_MON_TOGGLE_EN
    check({tag, "_toggle"},   32'(toggle_count), 32'(e.tog));
`endif

    obs_valid = 1'b1;
    obs_bit   = 1'b1;
    tick();
    tick();
    obs_valid = 1'b0;
    check({tag, "_hold_sig"},  32'(signature), 32'(e.sig));
    check({tag, "_hold_done"}, 32'(done),      32'd1);
  endtask

  initial begin
    logic [31:0] rbits;
    logic [15:0] mid_sig;

    rst = 1'b1;
    tick();
    tick();
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_done",     32'(done),       32'd0);
    check("rst_mismatch", 32'(mismatch),   32'd0);
    check("rst_sig",      32'(signature),  32'h0001);
    check("rst_ones",     32'(ones_count), 32'd0);
    rst = 1'b0;
    tick();

    check("model_zero4", 32'(model_sig(4, 32'h0)), 32'h1680);
    run_window("zeros_match",    4, 16'h1680, 32'h0, 32'h0);
    run_window("zeros_mismatch", 4, 16'h0000, 32'h0, 32'h0);
    run_window("zeros_gaps",     4, 16'h1680, 32'h0, 32'b1011);
    check("gaps_sig_vs_gapfree", 32'(signature), 32'h1680);
    run_window("len_zero",       0, 16'h0001, 32'h0, 32'h0);
    check("len_zero_sig",        32'(signature), 32'h0001);
    run_window("toggles",        5, 16'hFFFF, 32'b11001, 32'b00100);
    rbits = $urandom;
    run_window("random12",      12, model_sig(12, rbits), rbits, 32'h0);

    // start during RUN must not restart; then reset aborts the window
    window_len = 16'd4;
    golden_sig = 16'h1234;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    obs_valid  = 1'b1;
    obs_bit    = 1'b1;
    tick();
    tick();
    obs_valid  = 1'b0;
    mid_sig    = model_sig(2, 32'b11);
    window_len = 16'd1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("midrun_busy", 32'(busy),       32'd1);
    check("midrun_sig",  32'(signature),  32'(mid_sig));
    check("midrun_ones", 32'(ones_count), 32'd2);
    obs_valid = 1'b1;
    tick();
    obs_valid = 1'b0;
    check("midrun_no_done", 32'(done), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy),       32'd0);
    check("abort_done", 32'(done),       32'd0);
    check("abort_sig",  32'(signature),  32'h0001);
    check("abort_ones", 32'(ones_count), 32'd0);
    obs_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    obs_valid = 1'b0;
    check("abort_idle_done", 32'(done), 32'd0);
    check("abort_idle_sig",  32'(signature), 32'h0001);

    // reset wins over a simultaneous start
    rst        = 1'b1;
    start      = 1'b1;
    window_len = 16'd3;
    tick();
    rst        = 1'b0;
    start      = 1'b0;
    check("rst_vs_start_busy", 32'(busy), 32'd0);
    check("scoreboard_empty",  32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sig_window_monitor.md
SIG_WINDOW_MONITOR -- requirements
Module: sig_window_monitor

Interface
REQ-001 SHALL have parameter SIG_W, default 16: signature register width.
REQ-002 SHALL have parameter CNT_W, default 16: window-length and counter width.
REQ-003 SHALL have parameter POLY, default 16'hB400: Galois MISR feedback taps.
REQ-004 SHALL have parameter SEED, default 16'h0001: signature value loaded at window start.
REQ-005 SHALL have port I1470_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port I1477_rst, input, 1: reset; synchronous and active-high.
REQ-007 SHALL have port start, input, 1: begin an observation window.
REQ-008 SHALL have port window_len, input, CNT_W: number of valid samples in the window, sampled at start.
REQ-009 SHALL have port golden_sig, input, SIG_W: expected signature, latched at start.
REQ-010 SHALL have port obs_valid, input, 1: obs_bit is a sample this cycle.
REQ-011 SHALL have port obs_bit, input, 1: observed output of the upstream benchmark subcircuit.
REQ-012 SHALL have ports busy, done and mismatch, each output, 1: window active / window complete / signature differs from golden.
REQ-013 SHALL have ports signature (output, SIG_W) and ones_count (output, CNT_W).
REQ-014 SHALL have port toggle_count, output, CNT_W, present only when SIG_MON_TOGGLE_EN is defined.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE: IDLE->RUN on start; RUN->DONE when the sample count reaches window_len; DONE->RUN on start.
REQ-016 SHALL, on start in IDLE or DONE: load signature=SEED, clear counters, latch window_len and golden_sig, and clear done and mismatch.
REQ-017 SHALL ignore start while in RUN.
REQ-018 SHALL, on start with window_len=0, go straight to DONE on the next cycle with signature=SEED.
REQ-019 SHALL accept a sample only in a RUN cycle with obs_valid=1; cycles with obs_valid=0 change no state.
REQ-020 SHALL update the MISR per accepted sample as fb=signature[0]^obs_bit, then signature=(signature>>1)^(fb ? POLY : 0).
REQ-021 SHALL increment ones_count for each accepted sample with obs_bit=1; the count cannot exceed window_len, so no saturation logic is required.
REQ-022 SHALL assert done in the cycle after the final accepted sample and hold it while in DONE.
REQ-023 SHALL assert mismatch together with done when signature != latched golden_sig, valid only while done=1.
REQ-024 SHALL drive busy=1 exactly while in RUN.
REQ-025 SHALL hold signature and counters stable in DONE until the next start.

Reset
REQ-026 SHALL, with I1477_rst=1 at a rising edge, enter IDLE and set signature=SEED, all counts=0, and busy=done=mismatch=0.
REQ-027 SHALL treat reset asserted in RUN as an abort: no done pulse, and the partial signature is discarded.
REQ-028 SHALL give reset priority over a simultaneous start.

Configuration
REQ-029 SHALL, with SIG_MON_TOGGLE_EN defined, add toggle_count: +1 per accepted sample whose obs_bit differs from the previous accepted sample in the same window; the first sample never counts.
REQ-030 SHALL, without SIG_MON_TOGGLE_EN, omit the toggle_count port and the previous-bit register, with all other behaviour identical.

Structure
REQ-031 SHALL take SIG_W, CNT_W, POLY, SEED defaults and the FSM state enum from shared package sig_mon_pkg.
REQ-032 SHALL place the one-step MISR update in combinational sub-module sig_misr_step (inputs: cur, bit; output: next).

Verification
REQ-033 SHALL test: reset, then start with window_len=4 and golden=16'h1680, then 4 valid samples of 0 -> done=1 one cycle after the 4th sample, signature=16'h1680, mismatch=0, ones_count=0.
REQ-034 SHALL test: the same window with golden=16'h0000 -> done=1, mismatch=1.
REQ-035 SHALL test: window_len=4 with obs_valid gaps interleaved -> signature identical to the gap-free run, done only after the 4th valid sample.
REQ-036 SHALL test: start with window_len=0 -> done=1 next cycle, signature=16'h0001, ones_count=0.
REQ-037 SHALL test: start pulsed mid-RUN, then reset mid-RUN -> start has no effect; after reset state=IDLE, busy=0, done=0.
REQ-038 SHALL test, with SIG_MON_TOGGLE_EN defined: samples 1,0,0,1,1 -> toggle_count=2, ones_count=3.
